parity_frame_tx: RTL and testbench
==================================

Name: parity_frame_tx

Overview:
Transmit-side counterpart of the 9-bit parity frame check. Accepts bytes over a valid/ready handshake and appends an even-parity bit: frame = {^byte, byte}, so the XOR of all nine bits is 0. Presents each frame on a registered parallel bus for on-chip loopback into the receive-side parity check. Also serialises the frame onto a single UART-style line: start bit, 9 frame bits LSB first, stop bit.

Parameters:
CLKS_PER_BIT, 16, clk cycles per serial bit; legal range >= 1; counter width = max(1, $clog2(CLKS_PER_BIT))

Ports:
clk  input  1  system clock, rising edge
arst  input  1  reset, asynchronous, active-high
in_data  input  8  byte to send; sampled only on accept
in_valid  input  1  in_data valid
in_ready  output  1  block can accept; combinational from state/counter
frame  output  9  registered frame: bit 8 = parity, bits 7:0 = byte
frame_valid  output  1  one-cycle pulse, frame updated this cycle
tx  output  1  serial line, idle high, registered
busy  output  1  high from accept until end of stop bit

Behaviour:
- Reset values (arst high, asynchronous): state=IDLE, frame=9'h000, frame_valid=0, tx=1, busy=0, bit counter=0, cycle counter=0. in_ready=1 once arst deasserts.
- Accept: a rising edge where in_valid && in_ready.
  - At that edge: frame <= {^in_data, in_data}, frame_valid <= 1, tx <= 0, busy <= 1, state <= START, cycle counter <= 0.
- frame_valid: high for exactly the one cycle after the accept edge, otherwise 0. frame holds its value until the next accept.
- FSM states: IDLE, START, DATA, STOP. Cycle counter runs 0..CLKS_PER_BIT-1 in every non-IDLE state.
  - START: tx=0 for CLKS_PER_BIT cycles, then -> DATA with bit index 0.
  - DATA: tx=frame[idx] for CLKS_PER_BIT cycles per bit, idx 0..8. After idx 8 -> STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then -> IDLE and busy <= 0, unless a new accept occurs at that edge.
- Serial timing: with cycle 0 = the cycle after the accept edge:
  - start bit: cycles 0..N-1
  - frame bit i: cycles N(1+i)..N(2+i)-1
  - stop bit: cycles 10N..11N-1
- in_ready = (state==IDLE) || (state==STOP && counter==CLKS_PER_BIT-1). This allows gap-free streaming.
- Back-to-back accept in the final stop cycle:
  - next start bit begins the following cycle
  - busy stays 1
  - frame period is exactly 11*CLKS_PER_BIT cycles
- Input stability:
  - in_valid while in_ready=0 is ignored and not queued; no data loss is signalled (the source must hold).
  - in_data changes after accept do not affect frame or tx.
- CLKS_PER_BIT=1:
  - each state lasts one cycle
  - in_ready is high in the single stop cycle
  - a 9-bit data phase still takes 9 cycles
- arst mid-frame: immediate abort. tx=1, busy=0, frame=0, FSM to IDLE. No partial frame resumes after release.
- No combinational path from in_valid to any output other than none (in_ready does not depend on in_valid).

Test Plan:
- Reset: assert arst mid-idle and at time 0 -> tx=1, busy=0, frame_valid=0, frame=9'h000, in_ready=1 after release.
- Single byte, N=4, in_data=8'hA5 (4 ones) -> frame=9'h0A5, frame_valid pulses 1 cycle. tx: 0 for 4 cycles, then bits 1,0,1,0,0,1,0,1,0 at 4 cycles each, then 1 for 4 cycles. busy high 44 cycles.
- Odd-weight byte, in_data=8'h07 -> frame=9'h107, parity bit on tx = 1 during cycles 36..39.
- Back-to-back, N=4, in_valid held with 8'h01 then 8'h80:
  - second accept in cycle 43
  - next start bit in cycle 44, no idle gap
  - frames 9'h101 then 9'h180
- Busy rejection: pulse in_valid with 8'hFF during DATA -> no accept, frame and tx unchanged, first frame completes normally.
- Abort and loopback:
  - arst at cycle 20 of a frame -> tx=1 next cycle, in_ready=1 after release.
  - All 256 bytes, N=1, frame fed to the parity-check decoder -> decoder err=0 and out_byte equals the sent byte every time.

Source files
------------

// File: rtl/parity_frame_tx_if.sv
// Byte-in / frame-out bundle of the parity frame transmitter.
// The slave side is the transmitter; the master side is the byte source and frame/line observer.
interface parity_frame_tx_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [8:0] frame;
  logic       frame_valid;
  logic       tx;
  logic       busy;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  frame,
    input  frame_valid,
    input  tx,
    input  busy
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output frame,
    output frame_valid,
    output tx,
    output busy
  );
endinterface

// File: rtl/parity_frame_tx.sv
// Even-parity 9-bit frame transmitter: registered parallel frame for loopback,
// plus a UART-style serial line (start, 9 frame bits LSB first, stop).
module parity_frame_tx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic               clk,
  input  logic               arst,
  parity_frame_tx_if.slave   bus
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      idx_q, idx_d;
  logic [8:0]      frame_q, frame_d;
  logic            frame_valid_q, frame_valid_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;
  logic            cnt_last_s;
  logic            ready_s;
  logic            accept_s;

  // Ready in the last stop cycle lets a held source stream frames without a gap.
  assign cnt_last_s = (cnt_q == CNT_LAST);
  assign ready_s    = (state_q == IDLE) || ((state_q == STOP) && cnt_last_s);
  assign accept_s   = bus.in_valid && ready_s;

  assign bus.in_ready    = ready_s;
  assign bus.frame       = frame_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.tx          = tx_q;
  assign bus.busy        = busy_q;

  // State register; arst aborts any frame in flight.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      idx_q         <= 4'd0;
      frame_q       <= 9'h000;
      frame_valid_q <= 1'b0;
      tx_q          <= 1'b1;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      frame_q       <= frame_d;
      frame_valid_q <= frame_valid_d;
      tx_q          <= tx_d;
      busy_q        <= busy_d;
    end
  end

  // Next-state logic; tx_d is the line level for the coming cycle.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    frame_d       = frame_q;
    frame_valid_d = 1'b0;
    tx_d          = tx_q;
    busy_d        = busy_q;

    if (accept_s) begin
      frame_d       = {even_parity(bus.in_data), bus.in_data};
      frame_valid_d = 1'b1;
      tx_d          = 1'b0;
      busy_d        = 1'b1;
      state_d       = START;
      cnt_d         = '0;
      idx_d         = 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          tx_d   = 1'b1;
          busy_d = 1'b0;
        end
        START: begin
          if (cnt_last_s) begin
            state_d = DATA;
            cnt_d   = '0;
            idx_d   = 4'd0;
            tx_d    = frame_q[0];
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        DATA: begin
          if (cnt_last_s) begin
            cnt_d = '0;
            if (idx_q == 4'd8) begin
              state_d = STOP;
              tx_d    = 1'b1;
            end else begin
              idx_d = idx_q + 4'd1;
              tx_d  = frame_q[idx_q + 4'd1];
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        STOP: begin
          if (cnt_last_s) begin
            state_d = IDLE;
            cnt_d   = '0;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_parity_frame_tx.sv
// Directed-plus-random bench for parity_frame_tx against a bit-timing reference model.
module tb_parity_frame_tx;

  localparam int N4 = 4;
  localparam int N1 = 1;

  logic clk;
  logic arst;
  int   n_cmp;
  int   n_err;

  parity_frame_tx_if if4 ();
  parity_frame_tx_if if1 ();

  parity_frame_tx #(.CLKS_PER_BIT(N4)) u_dut4 (.clk(clk), .arst(arst), .bus(if4));
  parity_frame_tx #(.CLKS_PER_BIT(N1)) u_dut1 (.clk(clk), .arst(arst), .bus(if1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Reference: frame = {parity making total weight even, byte}.
  function automatic logic [8:0] mk_frame(input logic [7:0] b);
    logic p;
    p = ($countones(b) % 2) != 0;
    return {p, b};
  endfunction

  // Reference: line level t cycles after the accept edge, n cycles per bit.
  function automatic logic exp_tx(input logic [8:0] f, input int t, input int n);
    if (t < n) return 1'b0;
    else if (t < 10 * n) return f[t / n - 1];
    else return 1'b1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle4(input logic [8:0] f);
    check("idle_tx", 32'(if4.tx), 32'd1);
    check("idle_busy", 32'(if4.busy), 32'd0);
    check("idle_fv", 32'(if4.frame_valid), 32'd0);
    check("idle_ready", 32'(if4.in_ready), 32'd1);
    check("idle_frame", 32'(if4.frame), 32'(f));
  endtask

  // Present a byte at a negedge and let the next rising edge accept it.
  task automatic start4(input logic [7:0] b);
    @(negedge clk);
    if4.in_data  = b;
    if4.in_valid = 1'b1;
    check("pre_ready", 32'(if4.in_ready), 32'd1);
    @(posedge clk);
  endtask

  // Watch one full frame period after an accept edge.
  task automatic watch4(input logic [7:0] b, input bit has_next, input logic [7:0] nb,
                        input bit poke_busy);
    logic [8:0] f;
    f = mk_frame(b);
    for (int t = 0; t < 11 * N4; t++) begin
      @(negedge clk);
      if (t == 0) begin
        if4.in_valid = has_next;
        if4.in_data  = has_next ? nb : 8'($urandom);
      end
      if (poke_busy && t == 15) begin
        if4.in_valid = 1'b1;
        if4.in_data  = 8'hFF;
      end
      if (poke_busy && t == 18) if4.in_valid = 1'b0;
      check("tx", 32'(if4.tx), 32'(exp_tx(f, t, N4)));
      check("busy", 32'(if4.busy), 32'd1);
      check("fv", 32'(if4.frame_valid), (t == 0) ? 32'd1 : 32'd0);
      check("frame", 32'(if4.frame), 32'(f));
      check("ready", 32'(if4.in_ready), (t == 11 * N4 - 1) ? 32'd1 : 32'd0);
    end
    if (!has_next) begin
      @(negedge clk);
      check_idle4(f);
    end
  endtask

  initial begin
    logic [7:0] rb;
    logic [8:0] f;
    n_cmp = 0;
    n_err = 0;
    arst  = 1'b1;
    if4.in_data = 8'h00; if4.in_valid = 1'b0;
    if1.in_data = 8'h00; if1.in_valid = 1'b0;

    // Reset at time zero.
    #1;
    check("rst_tx", 32'(if4.tx), 32'd1);
    check("rst_busy", 32'(if4.busy), 32'd0);
    check("rst_fv", 32'(if4.frame_valid), 32'd0);
    check("rst_frame", 32'(if4.frame), 32'h000);
    repeat (2) @(negedge clk);
    arst = 1'b0;
    @(negedge clk);
    check_idle4(9'h000);

    // Directed frames: even-weight, odd-weight, then busy-time rejection.
    start4(8'hA5); watch4(8'hA5, 1'b0, 8'h00, 1'b0);
    start4(8'h07); watch4(8'h07, 1'b0, 8'h00, 1'b0);
    start4(8'h3C); watch4(8'h3C, 1'b0, 8'h00, 1'b1);

    // Mid-idle reset clears the held frame.
    @(negedge clk);
    arst = 1'b1;
    #1;
    check("rst_idle_frame", 32'(if4.frame), 32'h000);
    check("rst_idle_tx", 32'(if4.tx), 32'd1);
    @(negedge clk);
    arst = 1'b0;
    @(negedge clk);
    check_idle4(9'h000);

    // Gap-free streaming with in_valid held.
    start4(8'h01);
    watch4(8'h01, 1'b1, 8'h80, 1'b0);
    watch4(8'h80, 1'b0, 8'h00, 1'b0);

    // Random bytes.
    for (int k = 0; k < 4; k++) begin
      rb = 8'($urandom);
      start4(rb);
      watch4(rb, 1'b0, 8'h00, 1'b0);
    end

    // Abort at cycle 20 of a frame.
    start4(8'h5A);
    for (int t = 0; t <= 20; t++) begin
      @(negedge clk);
      if (t == 0) if4.in_valid = 1'b0;
    end
    arst = 1'b1;
    #1;
    check("abort_tx", 32'(if4.tx), 32'd1);
    check("abort_busy", 32'(if4.busy), 32'd0);
    check("abort_frame", 32'(if4.frame), 32'h000);
    @(negedge clk);
    arst = 1'b0;
    for (int t = 0; t < 12 * N4; t++) begin
      @(negedge clk);
      check("no_resume_tx", 32'(if4.tx), 32'd1);
      check("no_resume_ready", 32'(if4.in_ready), 32'd1);
    end

    // Loopback of every byte at one clock per bit through a behavioural decoder.
    for (int b = 0; b < 256; b++) begin
      @(negedge clk);
      if1.in_data  = 8'(b);
      if1.in_valid = 1'b1;
      @(posedge clk);
      f = mk_frame(8'(b));
      for (int t = 0; t < 11 * N1; t++) begin
        @(negedge clk);
        if (t == 0) begin
          if1.in_valid = 1'b0;
          check("lb_fv", 32'(if1.frame_valid), 32'd1);
          check("lb_err", ($countones(if1.frame) % 2 != 0) ? 32'd1 : 32'd0, 32'd0);
          check("lb_byte", 32'(if1.frame[7:0]), 32'(b));
        end
        check("lb_tx", 32'(if1.tx), 32'(exp_tx(f, t, N1)));
        check("lb_ready", 32'(if1.in_ready), (t == 11 * N1 - 1) ? 32'd1 : 32'd0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
